addsub_issue_ctrl: RTL and testbench

//  Initiator-side front end for the registered add/sub unit (P=1 add, P=0 sub, result registered LAT cycles after the operands).

---
 rtl/addsub_pkg.sv | 20 ++
 rtl/addsub_rsp_fifo.sv | 63 ++++++
 rtl/addsub_issue_ctrl.sv | 97 +++++++++
 tb/tb_addsub_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and types for the add/sub issue front end.
package addsub_pkg;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned TAG_W_DEF  = 4;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]  tag;
  } rsp_t;

  // Credit counter must represent 0..DEPTH inclusive.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/addsub_rsp_fifo.sv
// Synchronous result FIFO with first-word-fall-through read port.
module addsub_rsp_fifo
  import addsub_pkg::*;
#(
  parameter int unsigned W     = DATA_W_DEF + TAG_W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en_i) wptr_d = wptr_q + AW'(1);
    if (rd_en_i) rptr_d = rptr_q + AW'(1);
    case ({wr_en_i, rd_en_i})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q];
  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CNT_FULL);

  a_no_overflow:  assert property (@(posedge CLK) disable iff (!RST) !(wr_en_i && full_o));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RST) !(rd_en_i && empty_o));

endmodule

// File: rtl/addsub_issue_ctrl.sv
// Credit-limited issue/return front end for a registered add/sub unit.
module addsub_issue_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned LAT    = 1,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              alu_p,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int unsigned   CW       = credit_w(DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic [CW-1:0]    credits_q, credits_d;
  logic             acc, pop;
  logic [LAT-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q [LAT];
  logic             fifo_empty, fifo_full;
  logic [DATA_W+TAG_W-1:0] fifo_rd;

  assign alu_p = req_op;
  assign alu_a = req_a;
  assign alu_b = req_b;

  assign req_ready = RST && (credits_q != '0);
  assign acc       = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    credits_d = credits_q;
    case ({acc, pop})
      2'b10:   credits_d = credits_q - CW'(1);
      2'b01:   credits_d = credits_q + CW'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) credits_q <= CRED_MAX;
    else      credits_q <= credits_d;
  end

  // Valid/tag pipe tracks the unit's latency so alu_s is captured exactly when it is meaningful.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= acc;
      tag_q[0] <= req_tag;
      for (int unsigned i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  addsub_rsp_fifo #(
    .W     (DATA_W + TAG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .wr_en_i   (vld_q[LAT-1]),
    .wr_data_i ({alu_s, tag_q[LAT-1]}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rsp_valid           = !fifo_empty;
  assign {rsp_data, rsp_tag} = fifo_rd;
  assign busy                = (credits_q != CRED_MAX);

  a_credit_bound: assert property (@(posedge CLK) disable iff (!RST) credits_q <= CRED_MAX);
  a_full_no_wr:   assert property (@(posedge CLK) disable iff (!RST) !(fifo_full && vld_q[LAT-1]));

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// Bench: behavioural add/sub unit, queue-based reference model, directed and random traffic.
module tb_addsub_issue_ctrl;
  import addsub_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [DW-1:0] req_a = '0, req_b = '0;
  logic [TW-1:0] req_tag = '0;
  logic          alu_p;
  logic [DW-1:0] alu_a, alu_b, alu_s;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned npop   = 0;
  longint unsigned cyc = 0;
  logic [TW-1:0] tag_ctr = '0;

  addsub_issue_ctrl #(.DATA_W(DW), .TAG_W(TW), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_p(alu_p), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  // Behavioural registered add/sub unit with LAT cycles of latency.
  logic [DW-1:0] upipe [LAT];
  always @(posedge CLK) begin
    upipe[0] <= (alu_p == OP_ADD) ? alu_a + alu_b : alu_a - alu_b;
    for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
  end
  assign alu_s = upipe[LAT-1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: every accepted op is outstanding until popped; results due LAT+1 cycles after accept.
  typedef struct {
    logic [DW-1:0]   d;
    logic [TW-1:0]   t;
    longint unsigned rdy;
  } exp_t;
  exp_t q[$];

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) begin
      q.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("req_ready", req_ready, q.size() < DEPTH);
      chk("busy", busy, q.size() != 0);
      chk("rsp_valid", rsp_valid, (q.size() > 0) && (cyc >= q[0].rdy));
      if (rsp_valid && rsp_ready && q.size() > 0) begin
        chk("rsp_data", rsp_data, q[0].d);
        chk("rsp_tag", rsp_tag, q[0].t);
        void'(q.pop_front());
        npop++;
      end
      if (req_valid && req_ready) begin
        e.d   = req_op ? req_a + req_b : req_a - req_b;
        e.t   = req_tag;
        e.rdy = cyc + LAT + 1;
        q.push_back(e);
      end
    end
  end

  // All driver tasks start and end at posedge+1.
  task automatic send(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [TW-1:0] tag);
    int unsigned n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    forever begin
      @(negedge CLK);
      if (req_ready) break;
      n++;
      if (n > 200) begin chk("send_timeout", 0, 1); break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic stream(input int unsigned n, input int unsigned max_cyc, output int unsigned acc);
    acc = 0;
    for (int unsigned c = 0; c < max_cyc && acc < n; c++) begin
      req_valid = 1'b1;
      req_op    = 1'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = tag_ctr;
      @(negedge CLK);
      if (req_ready) begin acc++; tag_ctr++; end
      @(posedge CLK); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int unsigned n = 0;
    do begin @(negedge CLK); n++; end while (busy && n < 500);
    chk(nm, busy, 0);
    @(posedge CLK); #1;
  endtask

  typedef struct {
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    rsp_t          exp;
  } vec_t;

  initial begin
    vec_t        vecs [4];
    int unsigned acc, acc2, k, p0;

    vecs[0] = '{op: OP_ADD, a: 32'd5,          b: 32'd7, tag: 4'd3,  exp: '{data: 32'd12,         tag: 4'd3}};
    vecs[1] = '{op: OP_SUB, a: 32'd0,          b: 32'd1, tag: 4'd9,  exp: '{data: 32'hFFFF_FFFF,  tag: 4'd9}};
    vecs[2] = '{op: OP_ADD, a: 32'hFFFF_FFFF,  b: 32'd2, tag: 4'd10, exp: '{data: 32'd1,          tag: 4'd10}};
    vecs[3] = '{op: OP_SUB, a: 32'd100,        b: 32'd42,tag: 4'd15, exp: '{data: 32'd58,         tag: 4'd15}};

    repeat (3) @(negedge CLK);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_busy", busy, 0);
    @(posedge CLK); #1;
    RST = 1'b1;

    // Single ops: latency, arithmetic incl. wrap, busy returns low
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      k = 0;
      do begin @(negedge CLK); k++; end while (!rsp_valid && k < 50);
      chk("vec_latency", k, LAT + 1);
      chk("vec_data", rsp_data, vecs[i].exp.data);
      chk("vec_tag", rsp_tag, vecs[i].exp.tag);
      @(negedge CLK);
      chk("vec_busy_idle", busy, 0);
      @(posedge CLK); #1;
    end

    // Backpressure: only DEPTH accepts, then in-order release
    rsp_ready = 1'b0;
    tag_ctr   = '0;
    p0        = npop;
    stream(6, 12, acc);
    chk("bp_accepts", acc, DEPTH);
    @(negedge CLK);
    chk("bp_req_ready_low", req_ready, 0);
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    stream(2, 50, acc2);
    chk("bp_rest_accepts", acc2, 2);
    drain("bp_drain");
    chk("bp_pops", npop - p0, 6);

    // Full throughput: 16 accepts in 16 cycles
    p0 = npop;
    stream(16, 16, acc);
    chk("tp_accepts", acc, 16);
    drain("tp_drain");
    chk("tp_pops", npop - p0, 16);

    // Random backpressure around the zero-credit boundary
    p0 = npop;
    fork
      begin
        for (int i = 0; i < 600; i++) begin
          @(posedge CLK); #1;
          rsp_ready = ($urandom_range(0, 3) == 0);
        end
      end
      begin
        stream(60, 600, acc);
      end
    join
    chk("rnd_accepts", acc, 60);
    rsp_ready = 1'b1;
    drain("rnd_drain");
    chk("rnd_pops", npop - p0, 60);

    // Reset with ops outstanding
    rsp_ready = 1'b0;
    stream(3, 10, acc);
    chk("rst_pre_accepts", acc, 3);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("postrst_rsp_valid", rsp_valid, 0);
      chk("postrst_busy", busy, 0);
    end
    @(posedge CLK); #1;
    stream(5, 10, acc);
    chk("postrst_credits", acc, DEPTH);
    rsp_ready = 1'b1;
    stream(1, 20, acc2);
    chk("postrst_last", acc2, 1);
    drain("postrst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
